// File: rtl/logic_unit_mc.sv
// Multi-cycle bitwise logic unit: AND/OR/XOR/NOR of two WIDTH-bit operands,
// CHUNK bits per clock (LSB chunk first), valid/ready on both sides.
module logic_unit_mc #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             zero,
  output logic             busy
);

  localparam int N  = WIDTH / CHUNK;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  generate
    if (WIDTH % CHUNK != 0) begin : g_bad_chunk
      $error("logic_unit_mc: WIDTH must be a multiple of CHUNK");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic [CW-1:0]    cnt;
  logic [1:0]       op_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] partial;
  logic [WIDTH-1:0] result;
  logic [CHUNK-1:0] a_c;
  logic [CHUNK-1:0] b_c;
  logic [CHUNK-1:0] f_c;
  logic             last;

  assign last = (cnt == CW'(N - 1));

  // Chunk datapath; result merges the current chunk so the final edge can
  // load out directly without an extra cycle.
  always_comb begin
    a_c = a_r[int'(cnt) * CHUNK +: CHUNK];
    b_c = b_r[int'(cnt) * CHUNK +: CHUNK];
    unique case (op_r)
      2'b00:   f_c = a_c & b_c;
      2'b01:   f_c = a_c | b_c;
      2'b10:   f_c = a_c ^ b_c;
      default: f_c = ~(a_c | b_c);
    endcase
    result = partial;
    result[int'(cnt) * CHUNK +: CHUNK] = f_c;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (in_valid) state_nx = BUSY;
      BUSY:    if (last)     state_nx = DONE;
      DONE:    if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    busy      = 1'b0;
    out_valid = 1'b0;
    unique case (state)
      IDLE:    in_ready  = 1'b1;
      BUSY:    busy      = 1'b1;
      DONE:    out_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt     <= '0;
      op_r    <= '0;
      a_r     <= '0;
      b_r     <= '0;
      partial <= '0;
      out     <= '0;
      zero    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            op_r    <= op;
            a_r     <= A;
            b_r     <= B;
            partial <= '0;
            cnt     <= '0;
          end
        end
        BUSY: begin
          partial <= result;
          if (last) begin
            cnt  <= '0;
            out  <= result;
            zero <= (result == '0);
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_logic_unit_mc.sv
// Bench for logic_unit_mc: cycle-level reference model on the default
// instance plus transaction-level random sweeps on 16/16 and 64/4 instances.
module tb_logic_unit_mc;

  localparam int MN = 4;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;
  bit started = 1'b0;

  // default instance 32/8
  logic        in_valid, in_ready, out_valid, out_ready, zero, busy;
  logic [1:0]  op;
  logic [31:0] a, b, out;

  // sweep instances
  logic        s16_valid, s16_irdy, s16_ovalid, s16_ordy, s16_zero, s16_busy;
  logic [1:0]  s16_op;
  logic [15:0] s16_a, s16_b, s16_out;
  logic        s64_valid, s64_irdy, s64_ovalid, s64_ordy, s64_zero, s64_busy;
  logic [1:0]  s64_op;
  logic [63:0] s64_a, s64_b, s64_out;

  logic_unit_mc #(.WIDTH(32), .CHUNK(8)) dut (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .A(a), .B(b), .out_valid(out_valid), .out_ready(out_ready),
    .out(out), .zero(zero), .busy(busy));

  logic_unit_mc #(.WIDTH(16), .CHUNK(16)) dut16 (
    .clock(clock), .reset_n(reset_n), .in_valid(s16_valid), .in_ready(s16_irdy),
    .op(s16_op), .A(s16_a), .B(s16_b), .out_valid(s16_ovalid), .out_ready(s16_ordy),
    .out(s16_out), .zero(s16_zero), .busy(s16_busy));

  logic_unit_mc #(.WIDTH(64), .CHUNK(4)) dut64 (
    .clock(clock), .reset_n(reset_n), .in_valid(s64_valid), .in_ready(s64_irdy),
    .op(s64_op), .A(s64_a), .B(s64_b), .out_valid(s64_ovalid), .out_ready(s64_ordy),
    .out(s64_out), .zero(s64_zero), .busy(s64_busy));

  function automatic logic [63:0] lref(input logic [1:0] o, input logic [63:0] x, input logic [63:0] y);
    case (o)
      2'b00:   return x & y;
      2'b01:   return x | y;
      2'b10:   return x ^ y;
      default: return ~(x | y);
    endcase
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: phase 0 = waiting, 1..MN = computing, MN+1 = holding result.
  int          m_phase = 0;
  logic [31:0] m_res = '0;
  logic [31:0] m_out = '0;
  logic        m_zero = 1'b0;

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_phase = 0;
      m_out   = '0;
      m_zero  = 1'b0;
    end else if (m_phase == 0) begin
      if (in_valid) begin
        m_res   = 32'(lref(op, {32'b0, a}, {32'b0, b}));
        m_phase = 1;
      end
    end else if (m_phase <= MN) begin
      if (m_phase == MN) begin
        m_out   = m_res;
        m_zero  = (m_res == 0);
        m_phase = MN + 1;
      end else begin
        m_phase++;
      end
    end else if (out_ready) begin
      m_phase = 0;
    end
  end

  always @(negedge clock) begin
    if (started) begin
      chk("in_ready",  in_ready,  m_phase == 0);
      chk("busy",      busy,      m_phase >= 1 && m_phase <= MN);
      chk("out_valid", out_valid, m_phase == MN + 1);
      chk("out",       out,       m_out);
      chk("zero",      zero,      m_zero);
    end
  end

  task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        input int hold, output logic [31:0] r, output logic z);
    int g;
    int lat;
    out_ready = (hold == 0);
    op = o; a = x; b = y; in_valid = 1'b1;
    g = 0;
    while (!in_ready && g < 50) begin @(posedge clock); #1; g++; end
    @(posedge clock); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 100) begin
      chk("in_ready while busy", in_ready, 0);
      a = $urandom; b = $urandom; op = 2'($urandom);
      @(posedge clock); #1;
      lat++;
    end
    chk("latency", lat, MN);
    r = out;
    z = zero;
    repeat (hold) begin
      @(posedge clock); #1;
      chk("hold out_valid", out_valid, 1);
      chk("hold out", out, r);
      chk("hold in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    @(posedge clock); #1;
    chk("return to idle", in_ready, 1);
    out_ready = 1'b0;
  endtask

  task automatic sweep16(input int n);
    logic [1:0]  o;
    logic [15:0] x, y, e;
    int lat;
    @(posedge clock); #1;
    for (int i = 0; i < n; i++) begin
      o = 2'($urandom); x = 16'($urandom); y = 16'($urandom);
      if ($urandom_range(0, 7) == 0) y = x;
      s16_op = o; s16_a = x; s16_b = y; s16_ordy = 1'b0; s16_valid = 1'b1;
      @(posedge clock); #1;
      s16_valid = 1'b0; s16_a = 16'($urandom); s16_b = 16'($urandom);
      lat = 0;
      while (!s16_ovalid && lat < 40) begin @(posedge clock); #1; lat++; end
      e = 16'(lref(o, {48'b0, x}, {48'b0, y}));
      chk("s16 latency", lat, 1);
      chk("s16 out", s16_out, e);
      chk("s16 zero", s16_zero, e == 0);
      repeat ($urandom_range(0, 2)) @(posedge clock);
      #1 s16_ordy = 1'b1;
      @(posedge clock); #1;
      s16_ordy = 1'b0;
      chk("s16 idle", s16_irdy, 1);
    end
  endtask

  task automatic sweep64(input int n);
    logic [1:0]  o;
    logic [63:0] x, y, e;
    int lat;
    @(posedge clock); #1;
    for (int i = 0; i < n; i++) begin
      o = 2'($urandom); x = {$urandom, $urandom}; y = {$urandom, $urandom};
      if ($urandom_range(0, 7) == 0) y = x;
      s64_op = o; s64_a = x; s64_b = y; s64_ordy = 1'b0; s64_valid = 1'b1;
      @(posedge clock); #1;
      s64_valid = 1'b0;
      lat = 0;
      while (!s64_ovalid && lat < 100) begin
        s64_a = {$urandom, $urandom}; s64_b = {$urandom, $urandom}; s64_op = 2'($urandom);
        @(posedge clock); #1; lat++;
      end
      e = lref(o, x, y);
      chk("s64 latency", lat, 16);
      chk("s64 out", s64_out, e);
      chk("s64 zero", s64_zero, e == 0);
      repeat ($urandom_range(0, 2)) @(posedge clock);
      #1 s64_ordy = 1'b1;
      @(posedge clock); #1;
      s64_ordy = 1'b0;
      chk("s64 idle", s64_irdy, 1);
    end
  endtask

  initial begin
    logic [31:0] r;
    logic        z;
    in_valid = 1'b0; out_ready = 1'b0; op = '0; a = '0; b = '0;
    s16_valid = 1'b0; s16_ordy = 1'b0; s16_op = '0; s16_a = '0; s16_b = '0;
    s64_valid = 1'b0; s64_ordy = 1'b0; s64_op = '0; s64_a = '0; s64_b = '0;

    // reset held with random inputs
    repeat (4) begin
      @(posedge clock); #1;
      started = 1'b1;
      in_valid = 1'($urandom); out_ready = 1'($urandom);
      op = 2'($urandom); a = $urandom; b = $urandom;
    end
    chk("rst out", out, 0);
    chk("rst zero", zero, 0);
    chk("rst out_valid", out_valid, 0);
    chk("rst busy", busy, 0);
    in_valid = 1'b0; out_ready = 1'b0;
    reset_n = 1'b1;
    #1 chk("rst in_ready", in_ready, 1);

    run_op(2'b01, 32'hF0F0_0000, 32'h0000_0F0F, 0, r, z);
    chk("OR out", r, 32'hF0F0_0F0F);
    chk("OR zero", z, 0);
    run_op(2'b00, 32'hAAAA_AAAA, 32'h5555_5555, 0, r, z);
    chk("AND out", r, 32'h0);
    chk("AND zero", z, 1);
    run_op(2'b10, 32'hAAAA_AAAA, 32'h5555_5555, 0, r, z);
    chk("XOR out", r, 32'hFFFF_FFFF);
    chk("XOR zero", z, 0);
    run_op(2'b11, 32'h0, 32'h0, 0, r, z);
    chk("NOR out", r, 32'hFFFF_FFFF);
    chk("NOR zero", z, 0);
    run_op(2'b10, 32'h1234_5678, 32'h0F0F_0F0F, 5, r, z);
    chk("hold XOR out", r, 32'h1D3B_5977);

    // asynchronous reset in the middle of an operation (cnt==2)
    out_ready = 1'b0; op = 2'b01; a = 32'h0000_FFFF; b = 32'hFFFF_0000; in_valid = 1'b1;
    @(posedge clock); #1;
    in_valid = 1'b0;
    @(posedge clock); #1;
    @(posedge clock); #2;
    reset_n = 1'b0;
    #1;
    chk("abort out", out, 0);
    chk("abort zero", zero, 0);
    chk("abort busy", busy, 0);
    chk("abort out_valid", out_valid, 0);
    chk("abort in_ready", in_ready, 1);
    @(posedge clock); #1;
    reset_n = 1'b1;
    run_op(2'b01, 32'h00FF_00FF, 32'h0F00_0F00, 0, r, z);
    chk("after abort out", r, 32'h0FFF_0FFF);

    // random traffic on the default instance, checked by the model every cycle
    repeat (400) begin
      @(posedge clock); #1;
      in_valid = ($urandom_range(0, 3) != 0);
      out_ready = 1'($urandom);
      op = 2'($urandom);
      a = ($urandom_range(0, 9) == 0) ? 32'h0 : $urandom;
      b = ($urandom_range(0, 9) == 0) ? a : $urandom;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (8) @(posedge clock);
    #1 out_ready = 1'b0;

    fork
      sweep16(500);
      sweep64(500);
    join

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running, expected finished");
    $fatal(1);
  end

endmodule
